// File: rtl/vec_uop_splitter.sv
// Splits one decoded vector instruction into one micro-op per physical register
// of its LMUL group, with offset register indices, per-register element counts
// and a last flag.
module vec_uop_splitter #(
  parameter int VLEN      = 256,
  parameter int PAYLOAD_W = 32,
  parameter int VL_W      = $clog2(VLEN) + 1,
  parameter int EC_W      = $clog2(VLEN/8) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [4:0]           vd_in,
  input  logic [4:0]           vs1_in,
  input  logic [4:0]           vs2_in,
  input  logic [1:0]           lmul_in,
  input  logic [1:0]           sew_in,
  input  logic [VL_W-1:0]      vl_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [4:0]           uop_vd,
  output logic [4:0]           uop_vs1,
  output logic [4:0]           uop_vs2,
  output logic [2:0]           uop_idx,
  output logic [EC_W-1:0]      uop_elems,
  output logic                 uop_last,
  output logic [PAYLOAD_W-1:0] uop_payload
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [4:0]           vd_q, vs1_q, vs2_q;
  logic [1:0]           lmul_q, sew_q;
  logic [VL_W-1:0]      remaining;
  logic [2:0]           idx;
  logic [PAYLOAD_W-1:0] payload_q;

  logic            busy, retire, take, load, adv, last;
  logic [EC_W-1:0] per_reg, elems;
  logic [2:0]      group_max;

  assign busy      = (state == BUSY);
  assign per_reg   = EC_W'(VLEN >> (32'd3 + 32'(sew_q)));
  assign group_max = 3'((4'd1 << lmul_q) - 4'd1);
  assign elems     = (remaining < VL_W'(per_reg)) ? EC_W'(remaining) : per_reg;
  // last covers both vl running out and the group bound (clips vl > VLMAX)
  assign last      = busy & ((remaining <= VL_W'(per_reg)) | (idx == group_max));

  assign retire    = busy & ready_in & last;
  assign ready_out = ~busy | retire;
  assign take      = valid_in & ready_out;
  assign load      = take & (vl_in != '0);
  assign adv       = busy & ready_in & ~last;

  always_comb begin
    state_nxt = state;
    if (load)        state_nxt = BUSY;
    else if (retire) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      lmul_q    <= '0;
      sew_q     <= '0;
      remaining <= '0;
      idx       <= '0;
      payload_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        vd_q      <= vd_in;
        vs1_q     <= vs1_in;
        vs2_q     <= vs2_in;
        lmul_q    <= lmul_in;
        sew_q     <= sew_in;
        remaining <= vl_in;
        idx       <= '0;
        payload_q <= payload_in;
      end else if (adv) begin
        remaining <= remaining - VL_W'(elems);
        idx       <= idx + 3'd1;
      end else if (retire) begin
        remaining <= '0;
        idx       <= '0;
      end
    end
  end

  // All outputs derive from held state, so they stay frozen under backpressure.
  assign valid_out   = busy;
  assign uop_idx     = idx;
  assign uop_elems   = busy ? elems : '0;
  assign uop_last    = last;
  assign uop_vd      = vd_q  + {2'b00, idx};
  assign uop_vs1     = vs1_q + {2'b00, idx};
  assign uop_vs2     = vs2_q + {2'b00, idx};
  assign uop_payload = payload_q;

endmodule

// File: tb/tb_vec_uop_splitter.sv
// Directed bench for vec_uop_splitter: vector table for micro-op sequences plus
// hand sequences for zero vl, back-to-back, backpressure and async reset.
module tb_vec_uop_splitter;
  localparam int VLEN = 256;
  localparam int PW   = 32;
  localparam int VLW  = $clog2(VLEN) + 1;
  localparam int ECW  = $clog2(VLEN/8) + 1;

  logic            clk = 1'b0;
  logic            rst_n, valid_in, ready_out, valid_out, ready_in, uop_last;
  logic [4:0]      vd_in, vs1_in, vs2_in, uop_vd, uop_vs1, uop_vs2;
  logic [1:0]      lmul_in, sew_in;
  logic [VLW-1:0]  vl_in;
  logic [PW-1:0]   payload_in, uop_payload;
  logic [2:0]      uop_idx;
  logic [ECW-1:0]  uop_elems;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_uop_splitter #(.VLEN(VLEN), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .vd_in(vd_in), .vs1_in(vs1_in), .vs2_in(vs2_in), .lmul_in(lmul_in),
    .sew_in(sew_in), .vl_in(vl_in), .payload_in(payload_in),
    .valid_out(valid_out), .ready_in(ready_in), .uop_vd(uop_vd),
    .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_idx(uop_idx),
    .uop_elems(uop_elems), .uop_last(uop_last), .uop_payload(uop_payload)
  );

  typedef struct packed {
    logic [4:0]      vd, vs1, vs2;
    logic [1:0]      lmul, sew;
    logic [VLW-1:0]  vl;
    logic [PW-1:0]   pl;
    logic [3:0]      n;
    logic [7:0][7:0] el;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [4:0] vd, vs1, vs2, input logic [1:0] lmul, sew,
                              input int vl, input logic [PW-1:0] pl, input int n,
                              input logic [63:0] el);
    vec_t v;
    v.vd = vd; v.vs1 = vs1; v.vs2 = vs2; v.lmul = lmul; v.sew = sew;
    v.vl = VLW'(vl); v.pl = pl; v.n = 4'(n); v.el = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] vd, vs1, vs2, input logic [1:0] lmul, sew,
                       input logic [VLW-1:0] vl, input logic [PW-1:0] pl);
    valid_in = 1'b1; vd_in = vd; vs1_in = vs1; vs2_in = vs2;
    lmul_in = lmul; sew_in = sew; vl_in = vl; payload_in = pl;
  endtask

  // Drop valid and put garbage on the fields to prove they were latched.
  task automatic scramble();
    valid_in = 1'b0;
    vd_in = 5'($urandom); vs1_in = 5'($urandom); vs2_in = 5'($urandom);
    lmul_in = 2'($urandom); sew_in = 2'($urandom);
    vl_in = VLW'($urandom); payload_in = $urandom;
  endtask

  task automatic chk_uop(input string nm, input vec_t v, input int k);
    chk({nm, "_valid"}, 64'(valid_out), 64'd1);
    chk({nm, "_idx"},   64'(uop_idx), 64'(k));
    chk({nm, "_vd"},    64'(uop_vd),  64'(5'(v.vd  + 5'(k))));
    chk({nm, "_vs1"},   64'(uop_vs1), 64'(5'(v.vs1 + 5'(k))));
    chk({nm, "_vs2"},   64'(uop_vs2), 64'(5'(v.vs2 + 5'(k))));
    chk({nm, "_elems"}, 64'(uop_elems), 64'(v.el[k]));
    chk({nm, "_last"},  64'(uop_last), 64'(k == int'(v.n) - 1));
    chk({nm, "_pl"},    64'(uop_payload), 64'(v.pl));
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; ready_in = 1'b1; scramble();
    vecs[0] = mk(8, 16, 24, 2, 2, 30,  32'hA000_0001, 4, {8'd0,8'd0,8'd0,8'd0,8'd6,8'd8,8'd8,8'd8});
    vecs[1] = mk(3, 4, 5, 3, 0, 40,    32'hA000_0002, 2, {48'd0,8'd8,8'd32});
    vecs[2] = mk(30, 29, 28, 2, 2, 100, 32'hA000_0003, 4, {32'd0,8'd8,8'd8,8'd8,8'd8});
    vecs[3] = mk(0, 1, 2, 1, 3, 5,     32'hA000_0004, 2, {48'd0,8'd1,8'd4});
    vecs[4] = mk(31, 0, 7, 0, 1, 16,   32'hA000_0005, 1, {56'd0,8'd16});
    vecs[5] = mk(24, 8, 16, 3, 0, 256, 32'hA000_0006, 8, {8{8'd32}});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_last",  64'(uop_last), 64'd0);
    chk("rst_idx",   64'(uop_idx), 64'd0);
    chk("rst_elems", 64'(uop_elems), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      chk($sformatf("v%0d_ready", i), 64'(ready_out), 64'd1);
      drive(v.vd, v.vs1, v.vs2, v.lmul, v.sew, v.vl, v.pl);
      @(negedge clk);
      scramble();
      for (int k = 0; k < int'(v.n); k++) begin
        chk_uop($sformatf("v%0d_u%0d", i, k), v, k);
        @(negedge clk);
      end
      chk($sformatf("v%0d_done", i), 64'(valid_out), 64'd0);
    end

    // vl == 0: consumed without any micro-op
    drive(5'd1, 5'd2, 5'd3, 2'd1, 2'd2, '0, 32'h0);
    @(negedge clk);
    scramble();
    chk("vl0_valid", 64'(valid_out), 64'd0);
    chk("vl0_ready", 64'(ready_out), 64'd1);

    // back-to-back, no bubble
    drive(5'd1, 5'd2, 5'd3, 2'd0, 2'd2, VLW'(8), 32'hB000_000A);
    @(negedge clk);
    chk("b2b_a_valid", 64'(valid_out), 64'd1);
    chk("b2b_a_vd",    64'(uop_vd), 64'd1);
    chk("b2b_a_last",  64'(uop_last), 64'd1);
    chk("b2b_a_ready", 64'(ready_out), 64'd1);
    drive(5'd5, 5'd6, 5'd7, 2'd0, 2'd2, VLW'(4), 32'hB000_000B);
    @(negedge clk);
    scramble();
    chk("b2b_b_valid", 64'(valid_out), 64'd1);
    chk("b2b_b_vd",    64'(uop_vd), 64'd5);
    chk("b2b_b_elems", 64'(uop_elems), 64'd4);
    chk("b2b_b_pl",    64'(uop_payload), 64'hB000_000B);
    @(negedge clk);
    chk("b2b_done", 64'(valid_out), 64'd0);

    // backpressure on idx 1 of an LMUL4 group wrapping past v31
    drive(5'd30, 5'd0, 5'd0, 2'd2, 2'd2, VLW'(32), 32'hC0);
    @(negedge clk);
    scramble();
    chk("bp_vd0", 64'(uop_vd), 64'd30);
    @(negedge clk);
    chk("bp_idx1", 64'(uop_idx), 64'd1);
    ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", c), 64'(valid_out), 64'd1);
      chk($sformatf("bp_hold%0d_idx", c),   64'(uop_idx), 64'd1);
      chk($sformatf("bp_hold%0d_vd", c),    64'(uop_vd), 64'd31);
      chk($sformatf("bp_hold%0d_elems", c), 64'(uop_elems), 64'd8);
      chk($sformatf("bp_hold%0d_ready", c), 64'(ready_out), 64'd0);
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk("bp_idx2", 64'(uop_idx), 64'd2);
    chk("bp_vd2",  64'(uop_vd), 64'd0);
    chk("bp_last2", 64'(uop_last), 64'd0);
    @(negedge clk);
    chk("bp_idx3", 64'(uop_idx), 64'd3);
    chk("bp_vd3",  64'(uop_vd), 64'd1);
    chk("bp_last3", 64'(uop_last), 64'd1);
    @(negedge clk);
    chk("bp_done", 64'(valid_out), 64'd0);

    // asynchronous reset during idx 2
    drive(5'd4, 5'd4, 5'd4, 2'd2, 2'd2, VLW'(32), 32'hD0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    @(negedge clk);
    chk("rm_idx2", 64'(uop_idx), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_valid_async", 64'(valid_out), 64'd0);
    chk("rm_idx_async",   64'(uop_idx), 64'd0);
    chk("rm_ready_async", 64'(ready_out), 64'd1);
    #7 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rm_post%0d_valid", c), 64'(valid_out), 64'd0);
      chk($sformatf("rm_post%0d_ready", c), 64'(ready_out), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
